mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 139 +++++++++++++
 tb/tb_mult_div_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers and mthi/mtlo writes.
// Optional macro MDU_CANCEL_EN adds a cancel port that aborts the operation in flight.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             o_dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic w_cancel;
`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Results are formed from the latched operands, so the datapath is a
  // register-to-register path that has the full latency to settle.
  logic               w_is_signed;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div_zero;

  assign w_is_signed = ~r_op[0];
  assign w_a_ext     = {{WIDTH{w_is_signed & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext     = {{WIDTH{w_is_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod      = w_a_ext * w_b_ext;

  // Sign-magnitude divide: the most negative dividend over -1 wraps back to itself.
  assign w_a_neg    = w_is_signed & r_a[WIDTH-1];
  assign w_b_neg    = w_is_signed & r_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -r_a : r_a;
  assign w_b_mag    = w_b_neg ? -r_b : r_b;
  assign w_quo_mag  = w_a_mag / w_b_mag;
  assign w_rem_mag  = w_a_mag % w_b_mag;
  assign w_quo      = (w_a_neg ^ w_b_neg) ? -w_quo_mag : w_quo_mag;
  assign w_rem      = w_a_neg ? -w_rem_mag : w_rem_mag;
  assign w_div_zero = (r_b == '0);

  // Handshake: start is accepted only when busy=0 (start is not gated by a
  // ready; the pipeline stalls on busy|start). busy then stays high for the
  // operation latency and falls on the same edge that updates HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_cancel) begin
              r_state <= S_RUN;
              r_cnt   <= op[1] ? DIV_LAT : MULT_LAT;
              r_op    <= op;
              r_a     <= a;
              r_b     <= b;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          if (w_cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (!r_op[1]) begin
              {r_hi, r_lo} <= w_prod;
            end else if (!w_div_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy        = (r_cnt != '0);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  localparam int W    = 32;
  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dbg_state;
  logic         cancel;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MLAT), .DIV_CYCLES(DLAT)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy(busy),
    .hi(hi),
    .lo(lo),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural meaning of each op.
  function automatic logic [2*W-1:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                           input logic [W-1:0] mb, input logic [W-1:0] cur_hi,
                                           input logic [W-1:0] cur_lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [2*W-1:0]  res;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    res = {cur_hi, cur_lo};
    case (mop)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: if (mb != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: if (mb != 0) begin
        res = {ua % ub, ua / ub};
        res = {res[31:0], res[63:32]};
        res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic go_idle();
    start  = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [W-1:0] data);
    hi_we = hw;
    lo_we = lw;
    wdata = data;
    step();
    go_idle();
    if (hw) m_hi = data;
    if (lw) m_lo = data;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  // Issue one operation and follow it to completion, checking busy every cycle.
  task automatic run_op(input logic [1:0] pop, input logic [W-1:0] pa, input logic [W-1:0] pb,
                        input logic disturb, input logic with_we);
    logic [2*W-1:0] e;
    int             lat;
    e = model(pop, pa, pb, m_hi, m_lo);
    exp_q.push_back(e[2*W-1:W]);
    exp_q.push_back(e[W-1:0]);
    lat = pop[1] ? DLAT : MLAT;
    start = 1'b1;
    op    = pop;
    a     = pa;
    b     = pb;
    hi_we = with_we;
    lo_we = with_we;
    wdata = $urandom;
    step();
    go_idle();
    a  = $urandom;
    b  = $urandom;
    op = 2'($urandom_range(0, 3));
    check("state_run", 32'(dbg_state), 32'd1);
    for (int i = 0; i < lat; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("hi_hold", hi, m_hi);
      check("lo_hold", lo, m_lo);
      if (disturb) begin
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
      end
      step();
    end
    go_idle();
    check("busy_done", 32'(busy), 32'd0);
    m_hi = exp_q.pop_front();
    m_lo = exp_q.pop_front();
    check("res_hi", hi, m_hi);
    check("res_lo", lo, m_lo);
  endtask

  initial begin
    reset = 1'b1;
    op    = '0;
    a     = '0;
    b     = '0;
    wdata = '0;
    m_hi  = '0;
    m_lo  = '0;
    go_idle();
    step();
    step();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    write_hilo(1'b1, 1'b1, $urandom);
    write_hilo(1'b1, 1'b0, $urandom);
    write_hilo(1'b0, 1'b1, $urandom);

    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    run_op(2'd2, -32'sd7, 32'd2, 1'b0, 1'b0);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);
    run_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("divovf_hi", hi, 32'h0000_0000);
    check("divovf_lo", lo, 32'h8000_0000);

    run_op(2'd0, 32'h1234_5678, 32'd9, 1'b1, 1'b0);
    run_op(2'd1, 32'd3, 32'd4, 1'b0, 1'b1);
    check("start_wins_lo", lo, 32'd12);

    // Reset in cycle 3 of a divide, with start and writes also asserted.
    start = 1'b1;
    op    = 2'd2;
    a     = 32'd100;
    b     = 32'd7;
    step();
    go_idle();
    step();
    step();
    reset = 1'b1;
    start = 1'b1;
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0;
    go_idle();
    m_hi = '0;
    m_lo = '0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    run_op(2'd0, 32'd6, 32'hFFFF_FFF9, 1'b0, 1'b0);
    check("postrst_lo", lo, 32'hFFFF_FFD6);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        write_hilo(1'($urandom), 1'($urandom), $urandom);
      end else begin
        run_op(2'($urandom_range(0, 3)), pick_val(),
               ($urandom_range(0, 4) == 0) ? 32'd0 : pick_val(),
               1'($urandom), 1'($urandom));
      end
    end

`ifdef MDU_CANCEL_EN
    write_hilo(1'b1, 1'b0, 32'd5);
    write_hilo(1'b0, 1'b1, 32'd6);
    start = 1'b1;
    op    = 2'd0;
    a     = 32'd7;
    b     = 32'd8;
    step();
    go_idle();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_hi", hi, 32'd5);
    check("cancel_lo", lo, 32'd6);
    for (int i = 0; i < MLAT; i++) step();
    check("cancel_discard_lo", lo, 32'd6);
    start  = 1'b1;
    cancel = 1'b1;
    step();
    go_idle();
    check("cancel_start_busy", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
